// File: rtl/freq_meter_pkg.sv
// Shared types, default sizing and a width helper for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Smallest w >= 1 with 2**w >= n, i.e. wide enough to count 0 .. n-1.
  function automatic int clog2_w(input longint unsigned n);
    int w;
    w = 1;
    for (int i = 62; i >= 1; i--) begin
      if ((64'd1 << i) >= n) w = i;
    end
    return w;
  endfunction

  localparam int DEF_GATE_CYCLES = 100_000_000;
  localparam int DEF_GATE_W      = clog2_w(longint'(DEF_GATE_CYCLES));
  localparam int DEF_CNT_W       = 27;

endpackage

// File: rtl/freq_meter_if.sv
// Start request plus result handshake between the frequency meter and its consumer.
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic [CNT_W-1:0] meas_freq;
  logic             meas_valid;
  logic             meas_ready;
  logic             overflow;
  logic             busy;

  modport master (
    input  start, meas_ready,
    output meas_freq, meas_valid, overflow, busy
  );

  modport slave (
    output start, meas_ready,
    input  meas_freq, meas_valid, overflow, busy
  );

endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchronizer followed by a one-cycle rising-edge pulse; reusable for buttons.
module sync_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and
// hands each count to the consumer through a valid/ready handshake.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CONTINUOUS  = 0
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          sig_in,
  freq_meter_if.master  bus
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state_reg, state_next;
  logic [GATE_W-1:0] gate_cnt_reg, gate_cnt_next;
  logic [CNT_W-1:0]  edge_cnt_reg, edge_cnt_next;
  logic              ovf_reg, ovf_next;
  logic [CNT_W-1:0]  meas_freq_reg, meas_freq_next;
  logic              overflow_reg, overflow_next;
  logic [CNT_W-1:0]  edge_cnt_inc;
  logic              ovf_inc;
  logic              rise;
  logic              auto_start;

  assign auto_start = (CONTINUOUS != 0);

  sync_edge_det u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (sig_in),
    .rise   (rise)
  );

  // Saturating edge count; edges beyond the maximum only raise the sticky ovf.
  always_comb begin
    edge_cnt_inc = edge_cnt_reg;
    ovf_inc      = ovf_reg;
    if (rise) begin
      if (edge_cnt_reg == CNT_MAX) ovf_inc = 1'b1;
      else                         edge_cnt_inc = edge_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg     <= IDLE;
      gate_cnt_reg  <= '0;
      edge_cnt_reg  <= '0;
      ovf_reg       <= 1'b0;
      meas_freq_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gate_cnt_reg  <= gate_cnt_next;
      edge_cnt_reg  <= edge_cnt_next;
      ovf_reg       <= ovf_next;
      meas_freq_reg <= meas_freq_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Counters sit at zero outside MEASURE, so every window starts clean.
  always_comb begin
    state_next     = state_reg;
    gate_cnt_next  = '0;
    edge_cnt_next  = '0;
    ovf_next       = 1'b0;
    meas_freq_next = meas_freq_reg;
    overflow_next  = overflow_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.start || auto_start) state_next = MEASURE;
      end
      MEASURE: begin
        if (gate_cnt_reg == GATE_LAST) begin
          meas_freq_next = edge_cnt_inc;
          overflow_next  = ovf_inc;
          state_next     = HOLD;
        end else begin
          gate_cnt_next = gate_cnt_reg + 1'b1;
          edge_cnt_next = edge_cnt_inc;
          ovf_next      = ovf_inc;
        end
      end
      HOLD: begin
        if (bus.meas_ready) state_next = auto_start ? MEASURE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.meas_freq  = meas_freq_reg;
  assign bus.meas_valid = (state_reg == HOLD);
  assign bus.overflow   = overflow_reg;
  assign bus.busy       = (state_reg == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three instances (4-bit, 2-bit saturating, continuous) share sig_in.
module tb_freq_meter;

  localparam int G = 10;

  typedef struct {
    int       d;
    bit       q;
    bit [9:0] pat;
    int       freq;
    bit       ovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] start_v;
  logic [2:0] ready_v;
  logic       sig;
  logic [2:0] valid_v;
  logic [2:0] ovf_v;
  logic [2:0] busy_v;
  logic [3:0] freq_v [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int CW = (gi == 1) ? 2 : 4;
    freq_meter_if #(.CNT_W(CW)) bus ();
    assign bus.start      = start_v[gi];
    assign bus.meas_ready = ready_v[gi];
    assign valid_v[gi]    = bus.meas_valid;
    assign ovf_v[gi]      = bus.overflow;
    assign busy_v[gi]     = bus.busy;
    assign freq_v[gi]     = 4'(bus.meas_freq);
    freq_meter #(
      .GATE_CYCLES (G),
      .GATE_W      (4),
      .CNT_W       (CW),
      .CONTINUOUS  ((gi == 2) ? 1 : 0)
    ) dut (
      .clk_in (clk),
      .rst    (rst_v[gi]),
      .sig_in (sig),
      .bus    (bus)
    );
  end

  // Value of sig seen at each rising clock edge.
  int ecnt = 0;
  bit hist [0:8191];
  always @(posedge clk) begin
    hist[ecnt] <= sig;
    ecnt       <= ecnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A window opened by start sampled at edge t0 counts rising transitions of the
  // sampled input at edges t0-1 .. t0+G-2 (3-cycle detect latency, terminal included).
  function automatic int model_rises(input int t0);
    int n = 0;
    for (int k = t0 - 1; k <= t0 + G - 2; k++)
      if (hist[k] && !hist[k - 1]) n++;
    return n;
  endfunction

  task automatic run_vec(input vec_t v);
    sig = v.q;
    repeat (3) step();
    chk("vec idle busy", int'(busy_v[v.d]), 0);
    start_v[v.d] = 1'b1;
    sig = v.pat[0];
    step();
    start_v[v.d] = 1'b0;
    chk("vec busy", int'(busy_v[v.d]), 1);
    for (int i = 1; i < G; i++) begin
      sig = v.pat[i];
      step();
    end
    chk("vec early valid", int'(valid_v[v.d]), 0);
    sig = ~sig;
    step();
    chk("vec valid", int'(valid_v[v.d]), 1);
    chk("vec busy end", int'(busy_v[v.d]), 0);
    chk("vec freq", int'(freq_v[v.d]), v.freq);
    chk("vec ovf", int'(ovf_v[v.d]), int'(v.ovf));
    $display("vec dut=%0d q=%0d pat=%b freq=%0d ovf=%0d", v.d, v.q, v.pat, freq_v[v.d], ovf_v[v.d]);
  endtask

  task automatic accept(input int d, input int exp_freq);
    ready_v[d] = 1'b1;
    step();
    ready_v[d] = 1'b0;
    chk("accept valid drop", int'(valid_v[d]), 0);
    chk("accept freq kept", int'(freq_v[d]), exp_freq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    vec_t v;
    int   t0;
    int   n;
    int   r;
    int   e;
    int   pulses;
    bit   exp_valid;

    vecs[0] = '{0, 1'b0, 10'b1100110011, 3, 1'b0};  // period 4, 3 edges, last in terminal cycle
    vecs[1] = '{0, 1'b0, 10'b1000000000, 0, 1'b0};  // edge too late for the window
    vecs[2] = '{0, 1'b0, 10'b1100000000, 1, 1'b0};  // edge detected in terminal cycle
    vecs[3] = '{0, 1'b0, 10'b0000000001, 1, 1'b0};  // edge with the start cycle
    vecs[4] = '{0, 1'b0, 10'b0101010101, 5, 1'b0};  // maximum rate
    vecs[5] = '{0, 1'b1, 10'b1111111111, 0, 1'b0};  // constant high
    vecs[6] = '{1, 1'b0, 10'b0101010101, 3, 1'b1};  // 5 edges into 2-bit counter
    vecs[7] = '{1, 1'b0, 10'b0000010101, 3, 1'b0};  // exactly reaches max, no overflow
    vecs[8] = '{1, 1'b0, 10'b0001010101, 3, 1'b1};  // one edge past max

    rst_v   = 3'b111;
    start_v = 3'b000;
    ready_v = 3'b000;
    sig     = 1'b0;
    step();
    sig = 1'b1;
    step();
    for (int d = 0; d < 3; d++) begin
      chk("reset freq", int'(freq_v[d]), 0);
      chk("reset valid", int'(valid_v[d]), 0);
      chk("reset ovf", int'(ovf_v[d]), 0);
      chk("reset busy", int'(busy_v[d]), 0);
    end

    rst_v = 3'b100;
    for (int i = 0; i < 15; i++) begin
      sig = ~sig;
      step();
      chk("idle quiet", int'({busy_v[1:0], valid_v[1:0], ovf_v[1:0]}), 0);
    end
    chk("idle freq", int'(freq_v[0]), 0);

    run_vec(vecs[0]);
    for (int i = 0; i < 20; i++) begin
      sig        = i[0];
      start_v[0] = (i == 5);
      step();
      chk("backpressure valid", int'(valid_v[0]), 1);
      chk("backpressure freq", int'(freq_v[0]), 3);
      chk("backpressure busy", int'(busy_v[0]), 0);
    end
    start_v[0] = 1'b0;
    accept(0, 3);
    step();
    chk("no queued start", int'(busy_v[0]), 0);
    $display("backpressure held 20 cycles, accepted");

    start_v[0] = 1'b1;
    sig        = 1'b0;
    step();
    start_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig = ~sig;
      step();
    end
    chk("mid busy before rst", int'(busy_v[0]), 1);
    rst_v[0] = 1'b1;
    sig      = ~sig;
    step();
    rst_v[0] = 1'b0;
    chk("mid rst freq", int'(freq_v[0]), 0);
    chk("mid rst valid", int'(valid_v[0]), 0);
    chk("mid rst busy", int'(busy_v[0]), 0);
    chk("mid rst ovf", int'(ovf_v[0]), 0);
    $display("reset mid-window applied");
    v = '{0, 1'b0, 10'b0000000001, 1, 1'b0};
    run_vec(v);
    accept(0, 1);

    for (int i = 1; i < 9; i++) begin
      run_vec(vecs[i]);
      accept(vecs[i].d, vecs[i].freq);
    end

    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 4);
      for (int i = 0; i < r + 2; i++) begin
        sig = 1'($urandom_range(0, 1));
        step();
      end
      start_v[1:0] = 2'b11;
      t0  = ecnt;
      sig = 1'($urandom_range(0, 1));
      step();
      start_v[1:0] = 2'b00;
      for (int i = 1; i < G; i++) begin
        sig = 1'($urandom_range(0, 1));
        step();
      end
      chk("rand early valid", int'(valid_v[0]), 0);
      sig = 1'($urandom_range(0, 1));
      step();
      n = model_rises(t0);
      chk("rand valid0", int'(valid_v[0]), 1);
      chk("rand valid1", int'(valid_v[1]), 1);
      chk("rand freq0", int'(freq_v[0]), n);
      chk("rand ovf0", int'(ovf_v[0]), 0);
      chk("rand freq1", int'(freq_v[1]), (n > 3) ? 3 : n);
      chk("rand ovf1", int'(ovf_v[1]), int'(n > 3));
      $display("rand window %0d: edges=%0d freq4=%0d freq2=%0d ovf2=%0d", it, n, freq_v[0], freq_v[1], ovf_v[1]);
      r = $urandom_range(0, 3);
      for (int i = 0; i < r; i++) begin
        sig = 1'($urandom_range(0, 1));
        step();
      end
      ready_v[1:0] = 2'b11;
      step();
      ready_v[1:0] = 2'b00;
      chk("rand drop0", int'(valid_v[0]), 0);
      chk("rand drop1", int'(valid_v[1]), 0);
    end

    ready_v[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sig = ((ecnt % 5) < 2);
      step();
    end
    t0       = ecnt;
    rst_v[2] = 1'b0;
    pulses   = 0;
    for (int i = 0; i < 50; i++) begin
      sig = ((ecnt % 5) < 2);
      step();
      e = ecnt - 1;
      exp_valid = (e >= t0 + G) && (((e - t0 - G) % (G + 1)) == 0);
      chk("cont valid", int'(valid_v[2]), int'(exp_valid));
      chk("cont busy", int'(busy_v[2]), int'(!exp_valid));
      if (valid_v[2]) begin
        pulses++;
        chk("cont freq", int'(freq_v[2]), 2);
        $display("cont result at edge %0d: freq=%0d", e, freq_v[2]);
      end
    end
    chk("cont pulses", pulses, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
